// File: rtl/debug_uart_framer.sv
// Debug UART framer: captures debug GPIO changes and glitch-attempt records,
// frames them into a byte FIFO and drains the FIFO into uart_tx via the
// tx_start/tx_busy handshake. Also keeps the sticky success-code flag.
module debug_uart_framer #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter logic [7:0]  DEBUG_INIT = 8'h55,
  parameter logic [7:0]  MATCH_A    = 8'h88,
  parameter logic [7:0]  MATCH_B    = 8'h25
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            debug_in,
  input  logic                  debug_en,
  input  logic                  debug_force,
  input  logic                  rec_valid,
  output logic                  rec_ready,
  input  logic [15:0]           rec_a,
  input  logic [15:0]           rec_b,
  input  logic [15:0]           rec_c,
  input  logic                  hit_clr,
  output logic                  hit,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] REC_LEN = (DEPTH_LOG2 + 1)'(9);

  localparam logic       SER_IDLE  = 1'b0;
  localparam logic       SER_EMIT  = 1'b1;
  localparam logic [1:0] DRN_IDLE  = 2'd0;
  localparam logic [1:0] DRN_START = 2'd1;
  localparam logic [1:0] DRN_WAIT  = 2'd2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;

  logic                  ser_state;
  logic [3:0]            idx;
  logic [15:0]           lat_a;
  logic [15:0]           lat_b;
  logic [15:0]           lat_c;

  logic [7:0]            last_debug;
  logic [1:0]            drn_state;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   free_space;
  logic                  pop;
  logic                  rec_take;
  logic                  rec_accept;
  logic                  rec_drop;
  logic                  cap_trig;
  logic                  cap_match;
  logic                  cap_room;
  logic                  drop_inc;
  logic                  push;
  logic [7:0]            push_data;

  assign fifo_full  = (level == DEPTH_L);
  assign fifo_empty = (level == '0);
  assign free_space = DEPTH_L - level;

  assign pop        = (drn_state == DRN_IDLE) && !fifo_empty && !tx_busy;

  // Any offered record in IDLE is consumed; it is written only if it fits whole.
  assign rec_take   = (ser_state == SER_IDLE) && rec_valid;
  assign rec_accept = rec_take && (free_space >= REC_LEN);
  assign rec_drop   = rec_take && !rec_accept;

  // Capture is blocked while a frame is emitted or a record is taken this cycle;
  // last_debug is untouched then, so a pending change is seen again later.
  assign cap_trig   = (ser_state == SER_IDLE) && !rec_valid && debug_en &&
                      ((debug_in != last_debug) || debug_force);
  assign cap_match  = (debug_in == MATCH_A) || (debug_in == MATCH_B);
  // A simultaneous pop frees the head slot, so a full FIFO can still take a byte.
  assign cap_room   = !fifo_full || pop;
  assign drop_inc   = rec_drop || (cap_trig && !cap_room);

  // Select the byte to push: frame bytes during EMIT, else a captured debug byte.
  always_comb begin
    push      = 1'b0;
    push_data = 8'h00;
    if (ser_state == SER_EMIT) begin
      push = 1'b1;
      case (idx)
        4'd0:    push_data = 8'h55;
        4'd1:    push_data = 8'hAA;
        4'd2:    push_data = lat_a[15:8];
        4'd3:    push_data = lat_a[7:0];
        4'd4:    push_data = lat_b[15:8];
        4'd5:    push_data = lat_b[7:0];
        4'd6:    push_data = lat_c[15:8];
        4'd7:    push_data = lat_c[7:0];
        default: push_data = 8'h55;
      endcase
    end else if (cap_trig && cap_room) begin
      push      = 1'b1;
      push_data = debug_in;
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Record serializer: latch fields on accept, then emit nine bytes back to back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ser_state <= SER_IDLE;
      idx       <= 4'd0;
      lat_a     <= 16'h0000;
      lat_b     <= 16'h0000;
      lat_c     <= 16'h0000;
    end else if (ser_state == SER_IDLE) begin
      if (rec_accept) begin
        lat_a     <= rec_a;
        lat_b     <= rec_b;
        lat_c     <= rec_c;
        idx       <= 4'd0;
        ser_state <= SER_EMIT;
      end
    end else begin
      if (idx == 4'd8) begin
        idx       <= 4'd0;
        ser_state <= SER_IDLE;
      end else begin
        idx <= idx + 4'd1;
      end
    end
  end

  // Debug tracking, sticky hit (set beats clear) and saturating drop counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_debug <= DEBUG_INIT;
      hit        <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      if (cap_trig) begin
        last_debug <= debug_in;
      end
      if (cap_trig && cap_match) begin
        hit <= 1'b1;
      end else if (hit_clr) begin
        hit <= 1'b0;
      end
      if (drop_inc && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Drain FSM: pop into tx_data, hold tx_start until uart_tx goes busy, wait idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drn_state <= DRN_IDLE;
      tx_data   <= 8'h00;
    end else begin
      case (drn_state)
        DRN_IDLE: begin
          if (pop) begin
            tx_data   <= mem[rd_ptr];
            drn_state <= DRN_START;
          end
        end
        DRN_START: begin
          if (tx_busy) begin
            drn_state <= DRN_WAIT;
          end
        end
        DRN_WAIT: begin
          if (!tx_busy) begin
            drn_state <= DRN_IDLE;
          end
        end
        default: drn_state <= DRN_IDLE;
      endcase
    end
  end

  assign rec_ready  = (ser_state == SER_IDLE);
  assign tx_start   = (drn_state == DRN_START);
  assign fifo_level = level;

endmodule

// File: tb/tb_debug_uart_framer.sv
// Self-checking bench for debug_uart_framer: scoreboard of expected UART bytes
// fed by the stimulus tasks and consumed by a simple uart_tx model.
module tb_debug_uart_framer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  debug_in;
  logic        debug_en;
  logic        debug_force;
  logic        rec_valid;
  logic        rec_ready;
  logic [15:0] rec_a;
  logic [15:0] rec_b;
  logic [15:0] rec_c;
  logic        hit_clr;
  logic        hit;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [6:0]  fifo_level;
  logic [7:0]  drop_cnt;

  always #5 CLK = ~CLK;

  debug_uart_framer dut (
    .CLK         (CLK),
    .RST         (RST),
    .debug_in    (debug_in),
    .debug_en    (debug_en),
    .debug_force (debug_force),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_a       (rec_a),
    .rec_b       (rec_b),
    .rec_c       (rec_c),
    .hit_clr     (hit_clr),
    .hit         (hit),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         busy_cnt = 0;
  bit         model_en = 1'b0;
  bit         hold_busy = 1'b0;
  int         exp_drop = 0;
  logic [7:0] last_dbg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart_tx model: accepts a byte on tx_start, stays busy for 20 cycles.
  always @(negedge CLK) begin
    if (busy_cnt != 0) begin
      busy_cnt--;
    end else if (model_en && tx_start) begin
      if (exp_q.size() == 0) begin
        check_eq("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        exp_b = exp_q.pop_front();
        check_eq("tx_byte", 32'(tx_data), 32'(exp_b));
      end
      busy_cnt = 20;
    end
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic cap_byte(input logic [7:0] v, input bit stored);
    debug_in = v;
    last_dbg = v;
    if (stored) exp_q.push_back(v);
    else exp_drop++;
    @(negedge CLK);
  endtask

  task automatic send_rec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input bit accept, input bit inject);
    int n;
    rec_a = a;
    rec_b = b;
    rec_c = c;
    rec_valid = 1'b1;
    if (accept) begin
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
      exp_q.push_back(b[15:8]);
      exp_q.push_back(b[7:0]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(8'h55);
    end else begin
      exp_drop++;
    end
    @(negedge CLK);
    rec_valid = 1'b0;
    if (accept) begin
      n = 0;
      while (rec_ready == 1'b0 && n < 20) begin
        n++;
        if (inject && n == 1) debug_force = 1'b1;
        if (inject && n == 2) begin
          debug_force = 1'b0;
          debug_in = 8'hC3;
          last_dbg = 8'hC3;
          exp_q.push_back(8'hC3);
        end
        @(negedge CLK);
      end
      check_eq("rec_ready_low", 32'(n), 32'd9);
    end else begin
      check_eq("rec_ready_drop", 32'(rec_ready), 32'd1);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_cnt != 0 || fifo_level != 0) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sent;
    int n;
    bit saw_full;
    RST = 1'b1;
    debug_in = 8'h55;
    debug_en = 1'b0;
    debug_force = 1'b0;
    rec_valid = 1'b0;
    rec_a = 16'h0;
    rec_b = 16'h0;
    rec_c = 16'h0;
    hit_clr = 1'b0;
    last_dbg = 8'h55;
    repeat (2) @(negedge CLK);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_hit", 32'(hit), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    check_eq("rst_rec_ready", 32'(rec_ready), 32'd1);
    RST = 1'b0;
    model_en = 1'b1;

    // Debug changes: initial 0x55 equals reset value and must not be sent.
    debug_en = 1'b1;
    repeat (3) @(negedge CLK);
    check_eq("init_no_push", 32'(fifo_level), 32'd0);
    cap_byte(8'h0D, 1'b1);
    check_eq("hit_after_0d", 32'(hit), 32'd0);
    cap_byte(8'h88, 1'b1);
    check_eq("hit_after_88", 32'(hit), 32'd1);
    wait_drain("t1_drain");
    hit_clr = 1'b1;
    cap_byte(8'h25, 1'b1);
    hit_clr = 1'b0;
    check_eq("hit_set_wins", 32'(hit), 32'd1);
    hit_clr = 1'b1;
    @(negedge CLK);
    hit_clr = 1'b0;
    check_eq("hit_cleared", 32'(hit), 32'd0);
    wait_drain("t1b_drain");

    // Record framing.
    send_rec(16'h1234, 16'hBEEF, 16'h0001, 1'b1, 1'b0);
    wait_drain("t2_drain");

    // Debug change and force pulse during EMIT.
    send_rec(16'hA5A5, 16'h5A5A, 16'h0F0F, 1'b1, 1'b1);
    wait_drain("t3_drain");

    // Fill with uart busy; record with 7 bytes free is dropped whole.
    hold_busy = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 57; i++) cap_byte(8'(last_dbg + 8'd1), 1'b1);
    check_eq("fill_57", 32'(fifo_level), 32'd57);
    send_rec(16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
    check_eq("rec_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check_eq("rec_drop_level", 32'(fifo_level), 32'd57);
    for (int i = 0; i < 7; i++) cap_byte(8'(last_dbg + 8'd1), 1'b1);
    check_eq("fill_64", 32'(fifo_level), 32'd64);
    for (int i = 0; i < 3; i++) cap_byte(8'(last_dbg + 8'd1), 1'b0);
    check_eq("full_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check_eq("full_level", 32'(fifo_level), 32'd64);
    hold_busy = 1'b0;
    wait_drain("t4_drain");

    // Continuous traffic near full with pointer wrap.
    sent = 0;
    n = 0;
    saw_full = 1'b0;
    while (sent < 200 && n < 20000) begin
      if (fifo_level == 7'd64) saw_full = 1'b1;
      if (fifo_level < 7'd64) begin
        cap_byte(8'(last_dbg + 8'd1), 1'b1);
        sent++;
      end else begin
        @(negedge CLK);
      end
      n++;
    end
    check_eq("wrap_sent", 32'(sent), 32'd200);
    check_eq("wrap_full_seen", 32'(saw_full), 32'd1);
    wait_drain("t5_drain");

    // Reset asserted while tx_start is high.
    model_en = 1'b0;
    cap_byte(8'h25, 1'b1);
    n = 0;
    while (tx_start == 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_eq("start_seen", 32'(tx_start), 32'd1);
    check_eq("hit_pre_rst", 32'(hit), 32'd1);
    RST = 1'b1;
    debug_en = 1'b0;
    debug_in = 8'h55;
    #1;
    check_eq("rst_async_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_async_level", 32'(fifo_level), 32'd0);
    check_eq("rst_async_hit", 32'(hit), 32'd0);
    exp_q.delete();
    last_dbg = 8'h55;
    @(negedge CLK);
    RST = 1'b0;
    model_en = 1'b1;
    debug_en = 1'b1;
    cap_byte(8'h5A, 1'b1);
    wait_drain("t6_drain");
    check_eq("final_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
